spi_accel_sequencer: RTL and testbench

Autonomous sampling controller for the accelerometer SPI path. Sits between the AHB-Lite bus and the byte-level SPI engine, driving its `txdin`/`txgo`/`txrdy`/`rxdout` handshake. Runs the 8-byte burst-read transaction (read command, start address, six data bytes) either on software request or from a periodic timer. Publishes X/Y/Z as atomically updated, sign-extended bus registers, so the CPU never sequences individual SPI bytes.

---
 rtl/spi_accel_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_accel_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_sequencer.sv
// rtl/spi_accel_sequencer.sv - AHB-Lite accelerometer burst-read sequencer over a byte SPI engine
// Optional interrupt output and CTRL.IE bit: define SEQ_IRQ_EN.
module spi_accel_sequencer #(
  parameter logic [7:0] CMD_READ   = 8'h0B,
  parameter logic [7:0] START_ADDR = 8'h0E,
  parameter int         CS_GAP     = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
`ifdef SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic [7:0]  spi_txdin,
  output logic        spi_txgo,
  input  logic        spi_txrdy,
  input  logic [7:0]  spi_rxdout,
  output logic        acc_ssn
);

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SEND, S_WAIT_LO, S_WAIT_HI, S_CAPTURE, S_CS_HOLD, S_DONE
  } state_t;

  state_t       state, state_d;
  logic [2:0]   idx, idx_d;
  logic [7:0]   gap_cnt, gap_d;
  logic         ssn_d, go_d, cap, done;
  logic [7:0]   din_d, tx_byte;
  logic [5:0][7:0] shadow;

  logic         ap_valid, ap_write;
  logic [2:0]   ap_addr;
  logic         wr_ctrl, wr_period, wr_status;
  logic         ctrl_en, ctrl_ie, en_q, start_req;
  logic [23:0]  period, tmr;
  logic         tmr_load, timer_trig, trigger, busy;
  logic         new_flag, ovr_flag;
  logic [15:0]  x_reg, y_reg, z_reg, count;
  logic         unused_bits;

  assign unused_bits = &{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:24]};
  assign HREADYOUT   = 1'b1;

  // Address phase capture; the write itself lands in the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= 3'd0;
    end else if (HREADY) begin
      ap_valid <= HSEL & HTRANS[1];
      ap_write <= HWRITE;
      ap_addr  <= HADDR[4:2];
    end
  end

  assign wr_ctrl   = ap_valid & ap_write & (ap_addr == 3'd0);
  assign wr_period = ap_valid & ap_write & (ap_addr == 3'd1);
  assign wr_status = ap_valid & ap_write & (ap_addr == 3'd2);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en   <= 1'b0;
      en_q      <= 1'b0;
      start_req <= 1'b0;
      period    <= 24'd0;
    end else begin
      en_q      <= ctrl_en;
      start_req <= wr_ctrl & HWDATA[1];
      if (wr_ctrl)   ctrl_en <= HWDATA[0];
      if (wr_period) period  <= HWDATA[23:0];
    end
  end

`ifdef SEQ_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_ie <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_ie <= HWDATA[2];
      irq <= new_flag & ctrl_ie;
    end
  end
`else
  assign ctrl_ie = 1'b0;
`endif

  // Reload with PERIOD-1 after a trigger so consecutive triggers are exactly PERIOD apart.
  assign tmr_load   = (ctrl_en & ~en_q) | wr_period;
  assign timer_trig = ctrl_en & (period != 24'd0) & (tmr == 24'd0) & ~tmr_load;
  assign trigger    = start_req | timer_trig;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      tmr <= 24'd0;
    else if (tmr_load)
      tmr <= wr_period ? HWDATA[23:0] : period;
    else if (timer_trig)
      tmr <= period - 24'd1;
    else if (ctrl_en && tmr != 24'd0)
      tmr <= tmr - 24'd1;
  end

  always_comb begin
    case (idx)
      3'd0:    tx_byte = CMD_READ;
      3'd1:    tx_byte = START_ADDR;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      gap_cnt   <= 8'd0;
      acc_ssn   <= 1'b1;
      spi_txgo  <= 1'b0;
      spi_txdin <= 8'h00;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      gap_cnt   <= gap_d;
      acc_ssn   <= ssn_d;
      spi_txgo  <= go_d;
      spi_txdin <= din_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    gap_d   = gap_cnt;
    ssn_d   = acc_ssn;
    go_d    = 1'b0;
    din_d   = spi_txdin;
    cap     = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        ssn_d = 1'b1;
        if (trigger) begin
          ssn_d   = 1'b0;
          idx_d   = 3'd0;
          gap_d   = 8'd0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (gap_cnt == GAP_LAST) state_d = S_SEND;
        else                     gap_d   = gap_cnt + 8'd1;
      end
      S_SEND: begin
        if (spi_txrdy) begin
          go_d    = 1'b1;
          din_d   = tx_byte;
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: if (!spi_txrdy) state_d = S_WAIT_HI;
      S_WAIT_HI: if (spi_txrdy)  state_d = S_CAPTURE;
      S_CAPTURE: begin
        cap   = (idx >= 3'd2);
        idx_d = idx + 3'd1;
        if (idx == 3'd7) begin
          gap_d   = 8'd0;
          state_d = S_CS_HOLD;
        end else begin
          state_d = S_SEND;
        end
      end
      S_CS_HOLD: begin
        if (gap_cnt == GAP_LAST) begin
          ssn_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          gap_d = gap_cnt + 8'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Results publish together in DONE so software never sees a torn sample.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shadow   <= '0;
      x_reg    <= 16'd0;
      y_reg    <= 16'd0;
      z_reg    <= 16'd0;
      count    <= 16'd0;
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (cap) shadow[3'(idx - 3'd2)] <= spi_rxdout;
      if (done) begin
        x_reg <= {shadow[1], shadow[0]};
        y_reg <= {shadow[3], shadow[2]};
        z_reg <= {shadow[5], shadow[4]};
        count <= count + 16'd1;
      end
      if (done)                        new_flag <= 1'b1;
      else if (wr_status && HWDATA[1]) new_flag <= 1'b0;
      if (trigger && busy)             ovr_flag <= 1'b1;
      else if (wr_status && HWDATA[2]) ovr_flag <= 1'b0;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (ap_valid && !ap_write) begin
      case (ap_addr)
        3'd0:    HRDATA = {29'd0, ctrl_ie, 1'b0, ctrl_en};
        3'd1:    HRDATA = {8'd0, period};
        3'd2:    HRDATA = {29'd0, ovr_flag, new_flag, busy};
        3'd3:    HRDATA = {{16{x_reg[15]}}, x_reg};
        3'd4:    HRDATA = {{16{y_reg[15]}}, y_reg};
        3'd5:    HRDATA = {{16{z_reg[15]}}, z_reg};
        3'd6:    HRDATA = {16'd0, count};
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_accel_sequencer.sv
// tb/tb_spi_accel_sequencer.sv - scoreboard bench for spi_accel_sequencer with a byte SPI engine model
module tb_spi_accel_sequencer;

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HREADYOUT;
  logic [7:0]  spi_txdin, spi_rxdout;
  logic        spi_txgo, spi_txrdy, acc_ssn;
`ifdef SEQ_IRQ_EN
  logic        irq;
`endif

  spi_accel_sequencer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
`ifdef SEQ_IRQ_EN
    .irq(irq),
`endif
    .spi_txdin(spi_txdin), .spi_txgo(spi_txgo), .spi_txrdy(spi_txrdy),
    .spi_rxdout(spi_rxdout), .acc_ssn(acc_ssn)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int first_go = 0;
  int nbytes = 0;
  int ssn_rises = 0;
  int starts[$];
  logic [31:0] exp_rd[$];
  string       exp_nm[$];
  logic [7:0]  resp [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Read scoreboard: expectations pushed by bus_read, compared in the data phase.
  initial begin
    bit rd_ph;
    logic [31:0] e;
    string n;
    forever begin
      @(posedge HCLK);
      rd_ph = HRESETn && HSEL && HREADY && HTRANS[1] && !HWRITE;
      @(negedge HCLK);
      if (rd_ph) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read actual=0x%08h required=no read", HRDATA);
        end else begin
          e = exp_rd.pop_front();
          n = exp_nm.pop_front();
          check(n, HRDATA, e);
        end
      end
    end
  end

  // SPI byte monitor: every burst must be 0B,0E,00x6 with select held low.
  initial begin
    logic prev_ssn, prev_go;
    logic [7:0] eb;
    prev_ssn = 1'b1;
    prev_go  = 1'b0;
    forever begin
      @(negedge HCLK);
      if (prev_ssn && !acc_ssn) begin
        nbytes = 0;
        starts.push_back(cyc);
      end
      if (!prev_ssn && acc_ssn && HRESETn) begin
        check("burst_bytes", nbytes, 8);
        ssn_rises++;
      end
      if (spi_txgo) begin
        eb = (nbytes == 0) ? 8'h0B : (nbytes == 1) ? 8'h0E : 8'h00;
        check($sformatf("txdin_b%0d", nbytes), {24'd0, spi_txdin}, {24'd0, eb});
        check("ssn_low_at_txgo", {31'd0, acc_ssn}, 32'd0);
        check("txgo_not_back_to_back", {31'd0, prev_go}, 32'd0);
        if (nbytes == 0) first_go = cyc;
        nbytes++;
      end
      prev_go  = spi_txgo;
      prev_ssn = acc_ssn;
    end
  end

  // Byte engine model: busy for several cycles after txgo, then returns the scripted byte.
  initial begin
    int midx, k;
    spi_txrdy  = 1'b1;
    spi_rxdout = 8'h00;
    midx = 0;
    forever begin
      @(negedge HCLK);
      if (acc_ssn) midx = 0;
      if (spi_txgo) begin
        spi_txrdy = 1'b0;
        k = midx;
        midx++;
        repeat (6) @(negedge HCLK);
        spi_rxdout = (k >= 2 && k < 8) ? resp[k-2] : 8'hA5;
        spi_txrdy = 1'b1;
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    wr_cyc = cyc;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
    exp_rd.push_back(exp);
    exp_nm.push_back(nm);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic wait_done(input int max);
    int r0;
    bit ok;
    r0 = ssn_rises;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge HCLK);
      if (ssn_rises != r0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=timeout required=burst end within %0d cycles", max);
    end
    repeat (2) @(negedge HCLK);
  endtask

  task automatic set_resp(input logic [47:0] v);
    for (int i = 0; i < 6; i++) resp[i] = v[8*i +: 8];
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, $sformatf("%s_reg%0d", tag, a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
    HTRANS = 2'b00; HADDR = 32'd0; HWDATA = 32'd0;
    set_resp(48'h060504030201);
    repeat (3) @(negedge HCLK);
    check("rst_acc_ssn", {31'd0, acc_ssn}, 32'd1);
    check("rst_txgo", {31'd0, spi_txgo}, 32'd0);
    check("rst_txdin", {24'd0, spi_txdin}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HRESETn = 1'b1;
    read_all_zero("init");

    // Single software-started burst
    bus_write(3'd0, 32'd2);
    wait_done(400);
    check("ssn_latency", starts[starts.size()-1] - wr_cyc, 2);
    check("first_go_after_gap", {31'd0, (first_go - wr_cyc) >= 6}, 32'd1);
    bus_read(3'd3, 32'h0000_0201, "x_basic");
    bus_read(3'd4, 32'h0000_0403, "y_basic");
    bus_read(3'd5, 32'h0000_0605, "z_basic");
    bus_read(3'd2, 32'd2, "status_new");
    bus_read(3'd6, 32'd1, "count_1");
    bus_read(3'd0, 32'd0, "ctrl_start_reads0");

    // Sign extension
    bus_write(3'd2, 32'd2);
    set_resp(48'hFFFF7F7F8000);
    bus_write(3'd0, 32'd2);
    wait_done(400);
    bus_read(3'd3, 32'hFFFF_8000, "x_neg");
    bus_read(3'd4, 32'h0000_7F7F, "y_pos");
    bus_read(3'd5, 32'hFFFF_FFFF, "z_neg");
    bus_read(3'd6, 32'd2, "count_2");

    bus_write(3'd0, 32'd4);
`ifdef SEQ_IRQ_EN
    bus_read(3'd0, 32'd4, "ctrl_ie_rw");
`else
    bus_read(3'd0, 32'd0, "ctrl_bit2_absent");
`endif
    bus_write(3'd0, 32'd0);

    // Periodic sampling
    bus_write(3'd2, 32'd6);
    bus_write(3'd1, 32'd2000);
    bus_read(3'd1, 32'd2000, "period_rw");
    starts.delete();
    bus_write(3'd0, 32'd1);
    repeat (10150) @(negedge HCLK);
    bus_write(3'd0, 32'd0);
    repeat (200) @(negedge HCLK);
    check("periodic_starts", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      check($sformatf("period_spacing_%0d", i), starts[i] - starts[i-1], 2000);
    bus_read(3'd2, 32'd2, "status_periodic_no_ovr");
    bus_read(3'd6, 32'd7, "count_7");

    // Overrun with a period shorter than a burst
    bus_write(3'd2, 32'd6);
    bus_read(3'd2, 32'd0, "status_cleared");
    bus_write(3'd1, 32'd50);
    bus_write(3'd0, 32'd1);
    repeat (300) @(negedge HCLK);
    bus_write(3'd0, 32'd0);
    repeat (250) @(negedge HCLK);
    bus_read(3'd2, 32'd6, "status_ovr");
    bus_write(3'd2, 32'd4);
    bus_read(3'd2, 32'd2, "status_ovr_w1c");

    // Reset during byte 4
    set_resp(48'h665544332211);
    bus_write(3'd0, 32'd2);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge HCLK);
        if (nbytes == 5 && !acc_ssn) begin
          hit = 1'b1;
          break;
        end
      end
      check("reached_byte4", {31'd0, hit}, 32'd1);
    end
    #2 HRESETn = 1'b0;
    #1;
    check("async_rst_ssn", {31'd0, acc_ssn}, 32'd1);
    check("async_rst_txgo", {31'd0, spi_txgo}, 32'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    read_all_zero("postrst");
    repeat (10) @(negedge HCLK);
    bus_write(3'd0, 32'd2);
    wait_done(400);
    bus_read(3'd3, 32'h0000_2211, "x_after_rst");
    bus_read(3'd4, 32'h0000_4433, "y_after_rst");
    bus_read(3'd5, 32'h0000_6655, "z_after_rst");
    bus_read(3'd6, 32'd1, "count_after_rst");

`ifdef SEQ_IRQ_EN
    bus_write(3'd2, 32'd2);
    bus_write(3'd0, 32'd6);
    wait_done(400);
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'd2);
    repeat (2) @(negedge HCLK);
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    repeat (3) @(negedge HCLK);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
